// File: rtl/mem_port_arbiter_if.sv
// Split CPU instruction/data memory ports plus the shared physical memory port.
// slave is the arbiter's view; master is the CPU-and-memory side.
interface mem_port_arbiter_if;
   logic        imem_read;
   logic [31:0] imem_addr;
   logic        imem_resp;
   logic [31:0] imem_rdata;

   logic        dmem_read;
   logic        dmem_write;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_wmask;
   logic        dmem_resp;
   logic [31:0] dmem_rdata;

   logic        pmem_read;
   logic        pmem_write;
   logic [31:0] pmem_addr;
   logic [31:0] pmem_wdata;
   logic [3:0]  pmem_wmask;
   logic        pmem_resp;
   logic [31:0] pmem_rdata;

   logic [31:0] perf_conflict_count;

   modport slave (
      input  imem_read, imem_addr,
      input  dmem_read, dmem_write, dmem_addr, dmem_wdata, dmem_wmask,
      input  pmem_resp, pmem_rdata,
      output imem_resp, imem_rdata, dmem_resp, dmem_rdata,
      output pmem_read, pmem_write, pmem_addr, pmem_wdata, pmem_wmask,
      output perf_conflict_count
   );

   modport master (
      output imem_read, imem_addr,
      output dmem_read, dmem_write, dmem_addr, dmem_wdata, dmem_wmask,
      output pmem_resp, pmem_rdata,
      input  imem_resp, imem_rdata, dmem_resp, dmem_rdata,
      input  pmem_read, pmem_write, pmem_addr, pmem_wdata, pmem_wmask,
      input  perf_conflict_count
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises imem/dmem requests onto one memory port; request-to-resp >= 2 cycles, 3-cycle minimum spacing.
// Strobes are held until pmem_resp; one transaction in flight, ties alternate between ports.
module mem_port_arbiter (
   input  logic                clk,
   input  logic                rst,
   mem_port_arbiter_if.slave   mem_if
);

   typedef enum logic [2:0] {IDLE, I_BUSY, D_BUSY, I_RESP, D_RESP} state_e;
   typedef enum logic {SRC_IMEM = 1'b0, SRC_DMEM = 1'b1} src_e;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
   } pmem_req_t;

   state_e      state_q;
   src_e        last_served_q;
   logic        pmem_read_q;
   logic        pmem_write_q;
   pmem_req_t   req_q;
   logic [31:0] imem_rdata_q;
   logic [31:0] dmem_rdata_q;
   logic [31:0] conflict_cnt_q;

   logic imem_req;
   logic dmem_req;
   logic conflict;
   logic grant_dmem_d;

   always_comb begin
      imem_req     = mem_if.imem_read;
      dmem_req     = mem_if.dmem_read | mem_if.dmem_write;
      conflict     = imem_req & dmem_req;
      // On a tie the port not served last wins.
      grant_dmem_d = dmem_req & (~imem_req | (last_served_q == SRC_IMEM));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         last_served_q  <= SRC_IMEM;
         pmem_read_q    <= 1'b0;
         pmem_write_q   <= 1'b0;
         req_q          <= '0;
         imem_rdata_q   <= '0;
         dmem_rdata_q   <= '0;
         conflict_cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (conflict && (conflict_cnt_q != '1)) begin
                  conflict_cnt_q <= conflict_cnt_q + 32'd1;
               end
               if (grant_dmem_d) begin
                  req_q.addr <= mem_if.dmem_addr;
                  state_q    <= D_BUSY;
                  if (mem_if.dmem_write) begin
                     pmem_write_q <= 1'b1;
                     req_q.wdata  <= mem_if.dmem_wdata;
                     req_q.wmask  <= mem_if.dmem_wmask;
                  end else begin
                     pmem_read_q  <= 1'b1;
                     req_q.wmask  <= '0;
                  end
               end else if (imem_req) begin
                  req_q.addr  <= mem_if.imem_addr;
                  req_q.wmask <= '0;
                  pmem_read_q <= 1'b1;
                  state_q     <= I_BUSY;
               end
            end
            I_BUSY: begin
               if (mem_if.pmem_resp) begin
                  pmem_read_q   <= 1'b0;
                  imem_rdata_q  <= mem_if.pmem_rdata;
                  last_served_q <= SRC_IMEM;
                  state_q       <= I_RESP;
               end
            end
            D_BUSY: begin
               if (mem_if.pmem_resp) begin
                  pmem_read_q   <= 1'b0;
                  pmem_write_q  <= 1'b0;
                  if (pmem_read_q) begin
                     dmem_rdata_q <= mem_if.pmem_rdata;
                  end
                  last_served_q <= SRC_DMEM;
                  state_q       <= D_RESP;
               end
            end
            // The RESP cycle keeps a still-high request level from being re-granted.
            I_RESP, D_RESP: state_q <= IDLE;
            default:        state_q <= IDLE;
         endcase
      end
   end

   assign mem_if.imem_resp           = (state_q == I_RESP);
   assign mem_if.dmem_resp           = (state_q == D_RESP);
   assign mem_if.imem_rdata          = imem_rdata_q;
   assign mem_if.dmem_rdata          = dmem_rdata_q;
   assign mem_if.pmem_read           = pmem_read_q;
   assign mem_if.pmem_write          = pmem_write_q;
   assign mem_if.pmem_addr           = req_q.addr;
   assign mem_if.pmem_wdata          = req_q.wdata;
   assign mem_if.pmem_wmask          = req_q.wmask;
   assign mem_if.perf_conflict_count = conflict_cnt_q;

endmodule
